// File: rtl/dvsd_cmp_seq.sv
// dvsd_cmp_seq: multi-cycle magnitude comparator.
// Walks both operands MSB-first, DIGIT bits per clock. Signed compares
// flip the sign bits on capture so a plain unsigned digit compare yields
// two's-complement order. Results are registered and held until the next
// compare completes.
module dvsd_cmp_seq #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1,
  localparam int NDIG      = WIDTH / DIGIT,
  localparam int CW        = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than,
  output logic [CW-1:0]    digits_used
);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             dir_gt;

  logic             accept;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             diff;
  logic             last_dig;
  logic             finish;
  logic [WIDTH-1:0] sign_mask;

  // Digit slice under examination and the exit condition for this cycle.
  assign accept    = start_in && (state != COMPARE);
  assign dig_a     = sh_a[WIDTH-1 -: DIGIT];
  assign dig_b     = sh_b[WIDTH-1 -: DIGIT];
  assign diff      = (dig_a != dig_b);
  assign last_dig  = (cnt == CW'(NDIG - 1));
  assign finish    = (state == COMPARE) && (((EARLY_EXIT != 0) && diff) || last_dig);
  assign sign_mask = {signed_in, {(WIDTH-1){1'b0}}};

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_in) state_nxt = COMPARE;
      COMPARE: if (finish)   state_nxt = DONE;
      DONE:    state_nxt = start_in ? COMPARE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifting, first-difference tracking and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is reset, shift registers included, so the
    // block leaves reset fully deterministic with all-zero "no result" flags.
    if (!rst_n) begin
      sh_a         <= '0;
      sh_b         <= '0;
      cnt          <= '0;
      decided      <= 1'b0;
      dir_gt       <= 1'b0;
      less_than    <= 1'b0;
      equal_to     <= 1'b0;
      greater_than <= 1'b0;
      digits_used  <= '0;
    end else if (accept) begin
      sh_a    <= A_in ^ sign_mask;
      sh_b    <= B_in ^ sign_mask;
      cnt     <= '0;
      decided <= 1'b0;
      dir_gt  <= 1'b0;
    end else if (state == COMPARE) begin
      sh_a <= sh_a << DIGIT;
      sh_b <= sh_b << DIGIT;
      cnt  <= cnt + CW'(1);
      // Only the first differing digit sets the direction.
      if (!decided && diff) begin
        decided <= 1'b1;
        dir_gt  <= (dig_a > dig_b);
      end
      if (finish) begin
        digits_used <= cnt + CW'(1);
        if (decided) begin
          greater_than <= dir_gt;
          less_than    <= !dir_gt;
          equal_to     <= 1'b0;
        end else if (diff) begin
          greater_than <= (dig_a > dig_b);
          less_than    <= (dig_a < dig_b);
          equal_to     <= 1'b0;
        end else begin
          greater_than <= 1'b0;
          less_than    <= 1'b0;
          equal_to     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvsd_cmp_seq.sv
// Testbench for dvsd_cmp_seq: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance
// driven with the same requests. Expected results come from an integer
// compare model and are queued per instance; monitors pop on done.
module tb_dvsd_cmp_seq;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  typedef struct {
    logic       lt;
    logic       eq;
    logic       gt;
    logic [2:0] du;
    int         cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start_in;
  logic          signed_in;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;

  logic          busy1, done1, lt1, eq1, gt1;
  logic [2:0]    du1;
  logic          busy0, done0, lt0, eq0, gt0;
  logic [2:0]    du0;

  exp_t q1[$];
  exp_t q0[$];
  exp_t last1;
  exp_t last0;

  int cyc;
  int n_chk;
  int n_pass;

  dvsd_cmp_seq #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .signed_in(signed_in),
    .A_in(a_in), .B_in(b_in), .busy(busy1), .done(done1),
    .less_than(lt1), .equal_to(eq1), .greater_than(gt1), .digits_used(du1)
  );

  dvsd_cmp_seq #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .signed_in(signed_in),
    .A_in(a_in), .B_in(b_in), .busy(busy0), .done(done0),
    .less_than(lt0), .equal_to(eq0), .greater_than(gt0), .digits_used(du0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: integer ordering plus position of the first differing digit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input bit ee);
    exp_t e;
    int ia, ib, p;
    logic [W-1:0] x;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'({16'h0, a});
      ib = int'({16'h0, b});
    end
    e.lt = (ia < ib);
    e.eq = (ia == ib);
    e.gt = (ia > ib);
    e.du = 3'(N);
    if (ee && a != b) begin
      x = a ^ b;
      p = W - 1;
      while (!x[p]) p--;
      e.du = 3'((W - 1 - p) / D + 1);
    end
    e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.lt = 0; e.eq = 0; e.gt = 0; e.du = 0; e.cyc = 0;
    return e;
  endfunction

  // Queue expectations for both instances for a request accepted at edge acc.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int acc);
    exp_t e;
    e = model(a, b, s, 1'b1);
    e.cyc = acc + int'(e.du);
    q1.push_back(e);
    e = model(a, b, s, 1'b0);
    e.cyc = acc + int'(e.du);
    q0.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy1 || busy0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check("idle_timeout", t, 0);
  endtask

  // Single-cycle start pulse; operands are scrambled right after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    wait_idle();
    start_in  = 1'b1;
    a_in      = a;
    b_in      = b;
    signed_in = s;
    push_exp(a, b, s, cyc + 1);
    @(posedge clk); #1;
    start_in  = 1'b0;
    a_in      = W'($urandom);
    b_in      = W'($urandom);
    signed_in = 1'($urandom);
  endtask

  task automatic monitor_step(input int inst, input logic b, input logic d,
                              input logic lt, input logic eq, input logic gt,
                              input logic [2:0] du);
    exp_t e;
    string tag;
    tag = (inst == 1) ? "ee1" : "ee0";
    if (d) begin
      if ((inst == 1 && q1.size() == 0) || (inst == 0 && q0.size() == 0)) begin
        check({tag, "_spurious_done"}, d, 1'b0);
      end else begin
        e = (inst == 1) ? q1.pop_front() : q0.pop_front();
        check({tag, "_flags"}, {lt, eq, gt}, {e.lt, e.eq, e.gt});
        check({tag, "_digits_used"}, du, e.du);
        check({tag, "_done_cycle"}, cyc, e.cyc);
        check({tag, "_busy_at_done"}, b, 1'b0);
        if (inst == 1) last1 = e; else last0 = e;
      end
    end else if (b) begin
      e = (inst == 1) ? last1 : last0;
      check({tag, "_hold"}, {lt, eq, gt, du}, {e.lt, e.eq, e.gt, e.du});
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) if (rst_n) monitor_step(1, busy1, done1, lt1, eq1, gt1, du1);
  always @(negedge clk) if (rst_n) monitor_step(0, busy0, done0, lt0, eq0, gt0, du0);

  task automatic check_reset_state(input string name);
    check({name, "_ee1"}, {busy1, done1, lt1, eq1, gt1, du1}, 8'h00);
    check({name, "_ee0"}, {busy0, done0, lt0, eq0, gt0, du0}, 8'h00);
  endtask

  initial begin
    int acc;
    int t;
    logic [W-1:0] a, b;
    n_chk = 0; n_pass = 0; cyc = 0;
    last1 = zero_exp(); last0 = zero_exp();
    start_in = 0; signed_in = 0; a_in = 0; b_in = 0;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_initial");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    issue(16'h8000, 16'h7FFF, 1'b0);
    issue(16'h1234, 16'h1234, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b0);

    // Handshake: start held high through the first compare.
    wait_idle();
    start_in = 1'b1; signed_in = 1'b0;
    a_in = 16'h1235; b_in = 16'h1234;
    acc = cyc + 1;
    push_exp(16'h1235, 16'h1234, 1'b0, acc);
    @(posedge clk); #1;
    a_in = 16'h0000; b_in = 16'hFFFF;
    push_exp(16'h0000, 16'hFFFF, 1'b0, acc + N + 1);
    while (cyc < acc + N + 1) begin
      @(posedge clk); #1;
    end
    start_in = 1'b0;
    a_in = 16'h5555; b_in = 16'hAAAA;

    // Mid-operation reset during the second compare cycle.
    wait_idle();
    start_in = 1'b1; a_in = 16'h1234; b_in = 16'h1234; signed_in = 1'b0;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    q1.delete(); q0.delete();
    last1 = zero_exp(); last0 = zero_exp();
    #1;
    check_reset_state("reset_mid");
    repeat (6) @(posedge clk);
    check_reset_state("reset_held");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0001, 16'h0002, 1'b0);

    // Randomized requests: random, equal and single-digit-different operands.
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 2))
        0: b = W'($urandom);
        1: b = a;
        default: b = a ^ W'($urandom_range(1, 15) << (D * $urandom_range(0, N - 1)));
      endcase
      issue(a, b, 1'($urandom));
    end

    // Drain outstanding expectations.
    t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_ee1", q1.size(), 0);
    check("drain_ee0", q0.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
